// File: rtl/rsa_pkg.sv
// rsa_pkg: shared width default and FSM state encoding for the RSA blocks.
package rsa_pkg;
  localparam int RSA_WIDTH = 64;
  typedef logic [2:0] rsa_state_t;
  localparam rsa_state_t S_IDLE   = 3'd0;
  localparam rsa_state_t S_CHECK  = 3'd1;
  localparam rsa_state_t S_MUL    = 3'd2;
  localparam rsa_state_t S_UPDATE = 3'd3;
  localparam rsa_state_t S_FINISH = 3'd4;
endpackage

// File: rtl/rsa_modmul.sv
// rsa_modmul: bit-serial MSB-first interleaved modular multiply, p = x*y mod m after WIDTH steps.
module rsa_modmul #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] m,
  input  logic             go,
  output logic [WIDTH-1:0] p,
  output logic             valid
);
  localparam int KW = $clog2(WIDTH);
  logic [WIDTH+1:0] a_q, a_d, mm, dbl, red, sum;
  logic [KW-1:0] k_q;
  logic busy_q;
  // x and y are read live each step; the caller holds them stable while busy
  always_comb begin
    mm = {2'b00, m};
    dbl = a_q << 1;
    red = dbl >= mm ? dbl - mm : dbl;
    sum = red + (x[k_q] ? {2'b00, y} : '0);
    a_d = sum >= mm ? sum - mm : sum;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      k_q <= '0;
      busy_q <= 1'b0;
    end else if (go) begin
      a_q <= '0;
      k_q <= KW'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      a_q <= a_d;
      k_q <= k_q - KW'(1);
      busy_q <= k_q != '0;
    end
  assign p = a_q[WIDTH-1:0];
  assign valid = !busy_q;
endmodule

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: constant-time right-to-left square-and-multiply, result = base^exponent mod modulus.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             ready,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);
  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] LAST = KW'(WIDTH - 1);
  rsa_state_t st_q, st_d;
  logic [WIDTH-1:0] base_q, exp_q, mod_q, acc_r_q, acc_b_q, res_q, p_r, p_b, fin_val;
  logic [KW-1:0] i_q, mc_q;
  logic err_q, v_r, v_b, bad, go;
  assign bad = mod_q < WIDTH'(2) || base_q >= mod_q;
  assign go = st_q == S_CHECK || st_q == S_UPDATE;
  assign fin_val = err_q ? '0 : acc_r_q;
  always_comb
    st_d = st_q == S_IDLE   ? (start ? S_CHECK : S_IDLE) :
           st_q == S_CHECK  ? (bad ? S_FINISH : S_MUL) :
           st_q == S_MUL    ? (mc_q == LAST ? S_UPDATE : S_MUL) :
           st_q == S_UPDATE ? (i_q == LAST ? S_FINISH : S_MUL) : S_IDLE;
  rsa_modmul #(.WIDTH(WIDTH)) u_mul_r (.clk(clk), .rst(rst), .x(acc_r_q), .y(acc_b_q),
    .m(mod_q), .go(go), .p(p_r), .valid(v_r));
  rsa_modmul #(.WIDTH(WIDTH)) u_mul_b (.clk(clk), .rst(rst), .x(acc_b_q), .y(acc_b_q),
    .m(mod_q), .go(go), .p(p_b), .valid(v_b));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= S_IDLE;
      base_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
      acc_r_q <= '0;
      acc_b_q <= '0;
      res_q <= '0;
      i_q <= '0;
      mc_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      case (st_q)
        S_IDLE: if (start) begin
          base_q <= base;
          exp_q <= exponent;
          mod_q <= modulus;
          i_q <= '0;
        end
        S_CHECK: if (bad) err_q <= 1'b1;
        else begin
          acc_r_q <= WIDTH'(1);
          acc_b_q <= base_q;
          mc_q <= '0;
        end
        S_MUL: mc_q <= mc_q + KW'(1);
        S_UPDATE: begin
          // multiply result is always computed; the exponent bit only steers a mux
          if (v_r && v_b) begin
            acc_r_q <= exp_q[0] ? p_r : acc_r_q;
            acc_b_q <= p_b;
          end
          exp_q <= exp_q >> 1;
          i_q <= i_q + KW'(1);
          mc_q <= '0;
        end
        S_FINISH: begin
          res_q <= fin_val;
          exp_q <= '0;
          acc_r_q <= '0;
          acc_b_q <= '0;
          base_q <= '0;
          mod_q <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  assign ready = st_q == S_IDLE;
  assign done = st_q == S_FINISH;
  assign error = done && err_q;
  assign result = done ? fin_val : res_q;
endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: vector table, random operands vs. repeated-multiply model, ignored-start and reset corners.
module tb_rsa_modexp_core;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] base = '0, exponent = '0, modulus = '0;
  logic ready, done, error;
  logic [7:0] result;
  int total = 0, bad = 0;

  rsa_modexp_core #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .start(start), .base(base),
    .exponent(exponent), .modulus(modulus), .ready(ready), .done(done), .error(error),
    .result(result));

  always #5 clk = ~clk;

  typedef struct {
    int b;
    int e;
    int m;
    int res;
    int err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int b, input int e, input int m, output int r, output int er);
    longint acc = 1;
    if (m < 2 || b >= m) begin
      r = 0;
      er = 1;
    end else begin
      for (int k = 0; k < e; k++) acc = (acc * b) % m;
      r = int'(acc % m);
      er = 0;
    end
  endfunction

  // cycle numbering: cycle T0+n is the n-th negedge after the accept edge T0
  task automatic run(input int b, input int e, input int m, input int inj,
                     output int res, output int err, output int lat);
    int busy_ready = 0;
    @(negedge clk);
    base = 8'(b);
    exponent = 8'(e);
    modulus = 8'(m);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 999;
    res = -1;
    err = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (inj != 0 && c == inj) begin
        base = 8'd4;
        exponent = 8'd13;
        modulus = 8'd97;
        start = 1'b1;
      end else if (inj != 0 && c == inj + 1) start = 1'b0;
      if (done) begin
        lat = c;
        res = int'(result);
        err = int'(error);
        break;
      end
      if (ready) busy_ready++;
    end
    chk("ready_low_while_busy", busy_ready, 0);
    @(negedge clk);
    chk("ready_after_done", int'(ready), 1);
    chk("result_held", int'(result), res);
  endtask

  initial begin
    vec_t tbl[6];
    int r, er, lat, mr, me;
    tbl[0] = '{b: 88, e: 7,  m: 187, res: 11, err: 0};
    tbl[1] = '{b: 11, e: 23, m: 187, res: 88, err: 0};
    tbl[2] = '{b: 4,  e: 13, m: 97,  res: 93, err: 0};
    tbl[3] = '{b: 5,  e: 0,  m: 7,   res: 1,  err: 0};
    tbl[4] = '{b: 5,  e: 3,  m: 1,   res: 0,  err: 1};
    tbl[5] = '{b: 200, e: 7, m: 187, res: 0,  err: 1};

    repeat (2) @(negedge clk);
    chk("reset_ready", int'(ready), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_result", int'(result), 0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      run(tbl[k].b, tbl[k].e, tbl[k].m, 0, r, er, lat);
      chk($sformatf("vec%0d_result", k), r, tbl[k].res);
      chk($sformatf("vec%0d_error", k), er, tbl[k].err);
      chk($sformatf("vec%0d_latency", k), lat, tbl[k].err != 0 ? 2 : 74);
    end

    for (int n = 0; n < 20; n++) begin
      int b, e, m;
      m = int'($urandom_range(2, 255));
      b = (n % 5 == 4) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, m - 1));
      e = int'($urandom_range(0, 255));
      model(b, e, m, mr, me);
      run(b, e, m, 0, r, er, lat);
      chk($sformatf("rnd%0d_result(%0d^%0d mod %0d)", n, b, e, m), r, mr);
      chk($sformatf("rnd%0d_error", n), er, me);
      chk($sformatf("rnd%0d_latency", n), lat, me != 0 ? 2 : 74);
    end

    run(88, 7, 187, 10, r, er, lat);
    chk("ignored_start_result", r, 11);
    chk("ignored_start_latency", lat, 74);
    repeat (3) @(negedge clk);
    chk("ignored_start_no_second_done", int'(done), 0);
    chk("ignored_start_idle", int'(ready), 1);

    begin
      int seen = 0;
      @(negedge clk);
      base = 8'd88;
      exponent = 8'd7;
      modulus = 8'd187;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_result_during", int'(result), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", int'(ready), 1);
      chk("midrst_result", int'(result), 0);
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("midrst_no_done", seen, 0);
    end
    run(11, 23, 187, 0, r, er, lat);
    chk("after_rst_result", r, 88);
    chk("after_rst_error", er, 0);
    chk("after_rst_latency", lat, 74);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rsa_modexp_core.md
# rsa_modexp_core

Iterative RSA modular-exponentiation engine that computes result = base^exponent mod modulus. It is the consumer side of the key-generation path: it performs encryption with (n, e) and decryption or signing with (n, d). The engine is constant-time, so run time does not depend on exponent bits. The private exponent is never observable on any port and is zeroed internally after each operation.

## Interface
- WIDTH, 64: operand width in bits; must be ≥ 4.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request pulse; sampled only while ready=1
- base  in  WIDTH  message or ciphertext; sampled on accepted start
- exponent  in  WIDTH  e or d; sampled on accepted start
- modulus  in  WIDTH  n; sampled on accepted start
- ready  out  1  engine idle, start accepted; reset value 1
- done  out  1  one-cycle completion pulse; reset value 0
- error  out  1  valid with done; operands rejected; reset value 0
- result  out  WIDTH  holds last result until next done; reset value 0

## Operation
- States: IDLE, CHECK, MUL, UPDATE, FINISH.
- IDLE: ready=1. On start, latch base, exponent and modulus, then go to CHECK. Clear bit index i to 0.
- CHECK: error if modulus < 2 or base ≥ modulus. On error, go to FINISH with error flag set.
  - Otherwise set acc_r=1 and acc_b=base, then go to MUL.
- MUL: two rsa_modmul instances run in parallel for exactly WIDTH cycles.
  - p_r = acc_r·acc_b mod n
  - p_b = acc_b·acc_b mod n
- UPDATE, one cycle:
  - acc_r ← exp_sh[0] ? p_r : acc_r, implemented as a mux. No conditional skip.
  - acc_b ← p_b.
  - exp_sh ← exp_sh >> 1, i ← i+1.
  - If i == WIDTH-1, go to FINISH; else go to MUL.
- FINISH, one cycle:
  - done=1.
  - result ← error ? 0 : acc_r.
  - Zero exp_sh, acc_r, acc_b and the latched base/modulus.
  - Go to IDLE.
- Exponent 0 → result 1, since modulus ≥ 2.
- Arithmetic: modmul operates internally at WIDTH+2 bits. Inputs are < n, and each step reduces with at most one conditional subtract, so no overflow occurs.
- start while ready=0 is ignored and has no queueing.
- Security: no debug, bypass or test port exposes exponent or intermediate values. result changes only in FINISH.
- Reset mid-operation: all registers are zeroed immediately, and ready=1 on the first cycle after rst deasserts. No partial result appears.

## Timing
- Accept edge T0 (start & ready) → CHECK during cycle T0+1.
- Error path: done=error=1 in cycle T0+2.
- Normal path: WIDTH iterations of (WIDTH MUL cycles + 1 UPDATE cycle), then FINISH. done is high in cycle T0+2+WIDTH·(WIDTH+1).
  - For WIDTH=8, that is cycle T0+74.
- Latency is identical for every exponent value. ready returns to 1 the cycle after done.
- rsa_modmul: go pulse, then WIDTH cycles, MSB-first over x. Each step:
  - a ← 2a; if a ≥ m then a ← a−m.
  - if x[k] then a ← a+y; if a ≥ m then a ← a−m.
  - Its valid output is sampled in UPDATE.

## Structure
- Shared package rsa_pkg: WIDTH default and state enum, reused by keygen-side blocks.
- Sub-module rsa_modmul (x, y, m, go, p, valid), instantiated twice.
- Top-level FSM, exponent shifter and iteration counter live in rsa_modexp_core.

## Test plan
All scenarios use WIDTH=8.
- Encrypt: base=88, exponent=7, modulus=187 → result=11, error=0, done at T0+74.
- Decrypt: base=11, exponent=23, modulus=187 → result=88, same latency as the encrypt case. This confirms constant-time operation.
- base=4, exponent=13, modulus=97 → 93. base=5, exponent=0, modulus=7 → 1.
- Errors:
  - modulus=1 → done at T0+2, error=1, result=0.
  - base=200, modulus=187 → error=1.
- Ignored start: start pulsed at T0+10 with different operands → ignored; first result unchanged; ready stays 0 until after done.
- Reset mid-operation: assert rst at T0+30 → done never pulses, result=0, ready=1 after release. A fresh request then completes correctly.
